dac_spi_responder: RTL

- SPI responder model of the LTC2624-class quad 12-bit DAC: the target end of the DAC SPI link our DAC master drives.
- Oversamples SPI_SCK/DAC_CS/SPI_MOSI in the CLK50MHZ domain and decodes 32-bit frames {8'hxx, command[3:0], address[3:0], data[11:0], 4'hx}.
- Maintains per-channel input and DAC registers and echoes the previous frame on DAC_OUT.
- Used as a synthesizable loopback target on the board and as the bench responder for the master.

---
 rtl/dac_spi_pkg.sv | 26 ++
 rtl/spi_edge_sync.sv | 33 +++
 rtl/dac_spi_responder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/dac_spi_pkg.sv
// Shared DAC SPI definitions: command codes, frame field positions, FSM states.
// Imported by the responder and by the DAC master.
package dac_spi_pkg;

  localparam logic [3:0] CMD_WRITE            = 4'h0;
  localparam logic [3:0] CMD_UPDATE           = 4'h1;
  localparam logic [3:0] CMD_WRITE_UPDATE_ALL = 4'h2;
  localparam logic [3:0] CMD_WRITE_UPDATE     = 4'h3;
  localparam logic [3:0] CMD_NOP              = 4'hF;

  localparam logic [3:0] ADDR_ALL = 4'hF;

  localparam int CMD_HI  = 23;
  localparam int CMD_LO  = 20;
  localparam int ADDR_HI = 19;
  localparam int ADDR_LO = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchronizer with rise/fall detect on the synchronized level.
// Ports: clk, rst_n, din (async in), sync (level), rise/fall (1-cycle pulses).
module spi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Chain resets low: a CS held low across reset never yields a fall,
  // and a high CS after reset gives only a rise, which IDLE ignores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], din};
      prev  <= chain[STAGES-1];
    end
  end

  assign sync = chain[STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/dac_spi_responder.sv
// LTC2624-class quad DAC SPI responder: decodes 32-bit frames, keeps input/DAC regs.
// Ports: CLK50MHZ, RST (async low), SPI_SCK, DAC_CS, SPI_MOSI, DAC_CLR, DAC_OUT (MISO),
// dac_value, frame_valid, frame_error, last_command/address/data.
// Macro DAC_SPI_RESPONDER_ECHO_EN: echo previous valid frame on DAC_OUT.
import dac_spi_pkg::*;

module dac_spi_responder #(
  parameter int WIDTH       = 32,
  parameter int CHANNELS    = 4,
  parameter int DATA_BITS   = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLK50MHZ,
  input  logic                          RST,
  input  logic                          SPI_SCK,
  input  logic                          DAC_CS,
  input  logic                          SPI_MOSI,
  input  logic                          DAC_CLR,
  output logic                          DAC_OUT,
  output logic [CHANNELS*DATA_BITS-1:0] dac_value,
  output logic                          frame_valid,
  output logic                          frame_error,
  output logic [3:0]                    last_command,
  output logic [3:0]                    last_address,
  output logic [DATA_BITS-1:0]          last_data
);

  localparam int CW = $clog2(WIDTH + 2);

  logic sck_sync, sck_rise, sck_fall;
  logic cs_sync, cs_rise, cs_fall;
  logic mosi_sync, mosi_rise, mosi_fall;
  logic clr_sync, clr_rise, clr_fall;

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(CLK50MHZ), .rst_n(RST), .din(SPI_SCK),
    .sync(sck_sync), .rise(sck_rise), .fall(sck_fall));

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_cs (
    .clk(CLK50MHZ), .rst_n(RST), .din(DAC_CS),
    .sync(cs_sync), .rise(cs_rise), .fall(cs_fall));

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_mosi (
    .clk(CLK50MHZ), .rst_n(RST), .din(SPI_MOSI),
    .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall));

  spi_edge_sync #(.STAGES(SYNC_STAGES)) u_clr (
    .clk(CLK50MHZ), .rst_n(RST), .din(DAC_CLR),
    .sync(clr_sync), .rise(clr_rise), .fall(clr_fall));

  state_t                               state;
  logic [WIDTH-1:0]                     shift;
  logic [CW-1:0]                        cnt;
  logic [CHANNELS-1:0][DATA_BITS-1:0]   in_reg, in_nxt;
  logic [CHANNELS-1:0][DATA_BITS-1:0]   dac_reg, dac_nxt;

  logic [3:0]           f_cmd, f_addr;
  logic [DATA_BITS-1:0] f_data;
  logic                 accept, addr_ok;

  assign f_cmd   = shift[CMD_HI:CMD_LO];
  assign f_addr  = shift[ADDR_HI:ADDR_LO];
  assign f_data  = DATA_BITS'(shift[DATA_HI:DATA_LO]);
  assign accept  = (state == ST_DONE) && (cnt == CW'(WIDTH));
  assign addr_ok = (f_addr == ADDR_ALL) || (int'(f_addr) < CHANNELS);

  always_comb begin
    in_nxt  = in_reg;
    dac_nxt = dac_reg;
    if (accept && addr_ok) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (f_addr == ADDR_ALL || int'(f_addr) == i) begin
          case (f_cmd)
            CMD_WRITE,
            CMD_WRITE_UPDATE_ALL: in_nxt[i] = f_data;
            CMD_UPDATE:           dac_nxt[i] = in_reg[i];
            CMD_WRITE_UPDATE: begin
              in_nxt[i]  = f_data;
              dac_nxt[i] = f_data;
            end
            default: ;
          endcase
        end
      end
      // Broadcast update sees the value written by this same frame.
      if (f_cmd == CMD_WRITE_UPDATE_ALL) dac_nxt = in_nxt;
    end
  end

`ifdef DAC_SPI_RESPONDER_ECHO_EN
  logic [WIDTH-1:0] echo, last_frame;
  logic             dout;
`endif

  always_ff @(posedge CLK50MHZ or negedge RST) begin
    if (!RST) begin
      state        <= ST_IDLE;
      shift        <= '0;
      cnt          <= '0;
      in_reg       <= '0;
      dac_reg      <= '0;
      frame_valid  <= 1'b0;
      frame_error  <= 1'b0;
      last_command <= '0;
      last_address <= '0;
      last_data    <= '0;
`ifdef DAC_SPI_RESPONDER_ECHO_EN
      echo         <= '0;
      last_frame   <= '0;
      dout         <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      in_reg      <= clr_sync ? in_nxt  : '0;
      dac_reg     <= clr_sync ? dac_nxt : '0;
      unique case (state)
        ST_IDLE: begin
          if (cs_fall) begin
            state <= ST_SHIFT;
            cnt   <= '0;
`ifdef DAC_SPI_RESPONDER_ECHO_EN
            // MSB goes out now; echo holds the rest for SCK falls.
            dout  <= last_frame[WIDTH-1];
            echo  <= {last_frame[WIDTH-2:0], 1'b0};
`endif
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state <= ST_DONE;
`ifdef DAC_SPI_RESPONDER_ECHO_EN
            dout  <= 1'b0;
`endif
          end else begin
            if (sck_rise) begin
              shift <= {shift[WIDTH-2:0], mosi_sync};
              if (cnt != CW'(WIDTH + 1)) cnt <= cnt + 1'b1;
            end
`ifdef DAC_SPI_RESPONDER_ECHO_EN
            if (sck_fall) begin
              dout <= echo[WIDTH-1];
              echo <= {echo[WIDTH-2:0], 1'b0};
            end
`endif
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          if (cnt == CW'(WIDTH)) begin
            frame_valid  <= 1'b1;
            last_command <= f_cmd;
            last_address <= f_addr;
            last_data    <= f_data;
`ifdef DAC_SPI_RESPONDER_ECHO_EN
            last_frame   <= shift;
`endif
          end else begin
            frame_error <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DAC_SPI_RESPONDER_ECHO_EN
  assign DAC_OUT = dout;
`else
  assign DAC_OUT = 1'b0;
`endif

  assign dac_value = dac_reg;

  logic unused_ok;
  assign unused_ok = ^{sck_sync, cs_sync, mosi_rise, mosi_fall,
                       clr_rise, clr_fall, shift};

endmodule
